// File: rtl/riscv_immgen_pipe.sv
// Purpose : RISC-V immediate generator (I/S/B/U/J/SHAMT) behind a valid/ready register stage.
// Latency : 1 cycle from accept to out_valid; optional skid entry (`IMMGEN_SKID_EN) for full-rate stalls.
// Backpr. : default in_ready = !out_valid || out_ready; with skid, in_ready is a flop = "skid empty".
// Ports   : clk, rst_n (async active-low); in_valid/in_ready/ins_code in;
//           out_valid/out_ready/immediate/imm_fmt/illegal out. Param XLEN = 32 or 64.
module riscv_immgen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     ins_code,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immediate,
  output logic [2:0]      imm_fmt,
  output logic            illegal
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } res_t;

  res_t dec;
  res_t out_q, out_d;
  logic out_vld_q, out_vld_d;
  logic accept;

  // Combinational decode; signed casts replicate ins_code[31] up to XLEN.
  always_comb begin
    dec.imm = '0;
    dec.fmt = FMT_NONE;
    dec.ill = 1'b0;
    case (ins_code[6:0])
      7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(ins_code[31:20]));
      end
      7'b0010011: begin
        if (ins_code[13:12] == 2'b01) begin
          // funct3 001 / 101: shift amount, width follows XLEN
          dec.fmt = FMT_SHAMT;
          if (XLEN == 64) dec.imm = XLEN'(ins_code[25:20]);
          else            dec.imm = XLEN'(ins_code[24:20]);
        end else begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(ins_code[31:20]));
        end
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({ins_code[31:25], ins_code[11:7]}));
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({ins_code[31], ins_code[7], ins_code[30:25],
                                 ins_code[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({ins_code[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({ins_code[31], ins_code[19:12], ins_code[20],
                                 ins_code[30:21], 1'b0}));
      end
      7'b0110011: ; // R-type: legal, no immediate
      default: dec.ill = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;

`ifdef IMMGEN_SKID_EN
  res_t skid_q, skid_d;
  logic skid_vld_q, skid_vld_d;

  // Straight from a flop: no out_ready -> in_ready combinational path.
  assign in_ready = !skid_vld_q;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!out_vld_q || out_ready) begin
      // Output slot frees up: older skid entry has priority over new input.
      // While the skid is full in_ready is 0, so accept cannot coincide.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
`else
  assign in_ready = !out_vld_q || out_ready;

  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    if (accept) begin
      out_d     = dec;
      out_vld_d = 1'b1;
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign out_valid = out_vld_q;
  assign immediate = out_q.imm;
  assign imm_fmt   = out_q.fmt;
  assign illegal   = out_q.ill;

endmodule

// File: tb/tb_riscv_immgen_pipe.sv
// Bench for riscv_immgen_pipe: XLEN=32 and XLEN=64 instances share one input stream.
// Expected results come from an independent decode model, queued on accept and popped on drain.
module tb_riscv_immgen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] ins_code;
  logic        out_ready;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  always #5 clk = ~clk;

  riscv_immgen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .ins_code(ins_code), .out_valid(out_valid32), .out_ready(out_ready),
    .immediate(imm32), .imm_fmt(fmt32), .illegal(ill32));

  riscv_immgen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .ins_code(ins_code), .out_valid(out_valid64), .out_ready(out_ready),
    .immediate(imm64), .imm_fmt(fmt64), .illegal(ill64));

`ifdef IMMGEN_SKID_EN
  localparam int STALL_ACCEPTS = 2;
`else
  localparam int STALL_ACCEPTS = 1;
`endif

  typedef struct packed {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   acc_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] p_imm32;
  logic [2:0]  p_fmt;
  logic        p_ill;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode, built field by field from the ISA encodings.
  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    logic s;
    s = w[31];
    e.imm64 = 64'd0;
    e.imm32 = 32'd0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    case (w[6:0])
      7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        e.fmt = 3'd1; e.imm64 = {{52{s}}, w[31:20]};
      end
      7'b0010011: begin
        if (w[14:12] == 3'b001 || w[14:12] == 3'b101) begin
          e.fmt = 3'd6; e.imm64 = {58'd0, w[25:20]};
        end else begin
          e.fmt = 3'd1; e.imm64 = {{52{s}}, w[31:20]};
        end
      end
      7'b0100011: begin e.fmt = 3'd2; e.imm64 = {{52{s}}, w[31:25], w[11:7]}; end
      7'b1100011: begin
        e.fmt = 3'd3; e.imm64 = {{51{s}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin e.fmt = 3'd4; e.imm64 = {{32{s}}, w[31:12], 12'd0}; end
      7'b1101111: begin
        e.fmt = 3'd5; e.imm64 = {{43{s}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      end
      7'b0110011: ;
      default: e.ill = 1'b1;
    endcase
    if (e.fmt == 3'd6) e.imm32 = {27'd0, w[24:20]};
    else               e.imm32 = e.imm64[31:0];
    return e;
  endfunction

  // Scoreboard: sampled on the falling edge, between rising-edge updates.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (stall_prev) begin
        check("hold_valid", {63'd0, out_valid32}, 64'd1);
        check("hold_imm", {32'd0, imm32}, {32'd0, p_imm32});
        check("hold_fmt", {61'd0, fmt32}, {61'd0, p_fmt});
        check("hold_ill", {63'd0, ill32}, {63'd0, p_ill});
      end
      if (out_valid32 && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", {32'd0, imm32}, 64'd0);
          check("unexpected_output_q", 64'd0, 64'd1);
        end else begin
          e = q.pop_front();
          check("sb_imm32", {32'd0, imm32}, {32'd0, e.imm32});
          check("sb_fmt32", {61'd0, fmt32}, {61'd0, e.fmt});
          check("sb_ill32", {63'd0, ill32}, {63'd0, e.ill});
          check("sb_imm64", imm64, e.imm64);
          check("sb_fmt64", {61'd0, fmt64}, {61'd0, e.fmt});
          check("sb_vld64", {63'd0, out_valid64}, 64'd1);
        end
      end
      if (in_valid && in_ready32) begin
        q.push_back(ref_dec(ins_code));
        acc_cnt++;
      end
      stall_prev = out_valid32 && !out_ready;
      p_imm32 = imm32;
      p_fmt   = fmt32;
      p_ill   = ill32;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-shot directed vector with out_ready high: result must be on the outputs one cycle later.
  task automatic chk_vec(input string tag, input logic [31:0] w, input logic [31:0] e32,
                         input logic [63:0] e64, input logic [2:0] ef, input logic ei);
    in_valid = 1'b1;
    ins_code = w;
    step();
    in_valid = 1'b0;
    check({tag, "_vld"}, {63'd0, out_valid32}, 64'd1);
    check({tag, "_imm32"}, {32'd0, imm32}, {32'd0, e32});
    check({tag, "_imm64"}, imm64, e64);
    check({tag, "_fmt"}, {61'd0, fmt32}, {61'd0, ef});
    check({tag, "_ill"}, {63'd0, ill32}, {63'd0, ei});
  endtask

  task automatic send(input logic [31:0] w, input bit rnd_rdy);
    logic a;
    a = 1'b0;
    in_valid = 1'b1;
    ins_code = w;
    for (int k = 0; k < 100; k++) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      #1;
      a = in_ready32;
      @(posedge clk);
      #1;
      if (a) break;
    end
    check("send_accept", {63'd0, a}, 64'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (q.size() == 0 && !out_valid32) break;
      step();
    end
    check("drain_q", 64'(q.size()), 64'd0);
    check("drain_vld", {63'd0, out_valid32}, 64'd0);
  endtask

  initial begin
    logic [6:0]  ops [12];
    logic [31:0] w;
    int          base;
    ops = '{7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011, 7'b0010011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0101011};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ins_code = 32'd0;
    #12;
    check("rst_vld", {63'd0, out_valid32}, 64'd0);
    check("rst_imm", imm64, 64'd0);
    check("rst_fmt", {61'd0, fmt32}, 64'd0);
    check("rst_ill", {63'd0, ill32}, 64'd0);
    check("rst_rdy", {62'd0, in_ready32, in_ready64}, 64'd3);
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;

    chk_vec("addi", 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    chk_vec("sw",   32'hFE20AE23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
    chk_vec("beq",  32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0);
    chk_vec("slli", 32'h01F09093, 32'h0000001F, 64'h000000000000001F, 3'd6, 1'b0);
    chk_vec("lui",  32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    chk_vec("jal",  32'h0000006F, 32'h00000000, 64'h0000000000000000, 3'd5, 1'b0);
    chk_vec("ill",  32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b1);
    chk_vec("add",  32'h00B50533, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0);
    chk_vec("low2", 32'hFFF00090, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b1);
    drain();

    // Back-to-back with out_ready held high: one accept per cycle.
    base = acc_cnt;
    for (int i = 0; i < 20; i++) begin
      w = $urandom();
      w[6:0] = ops[i % 12];
      send(w, 1'b0);
    end
    in_valid = 1'b0;
    check("full_rate", 64'(acc_cnt - base), 64'd20);
    drain();

    // Random opcodes under random backpressure.
    for (int i = 0; i < 200; i++) begin
      w = $urandom();
      if (i % 7 != 0) w[6:0] = ops[$urandom_range(0, 11)];
      send(w, 1'b1);
    end
    drain();

    // Stall: in_valid held, out_ready low for three cycles.
    out_ready = 1'b0;
    step();
    base = acc_cnt;
    in_valid = 1'b1;
    ins_code = 32'h00100093;
    step();
    ins_code = 32'h00200113;
    step();
    ins_code = 32'h00300193;
    step();
    check("stall_accepts", 64'(acc_cnt - base), 64'(STALL_ACCEPTS));
    check("stall_in_rdy", {63'd0, in_ready32}, 64'd0);
    check("stall_q", 64'(q.size()), 64'(STALL_ACCEPTS));
    drain();

    // Asynchronous reset while a result is stalled.
    out_ready = 1'b0;
    send(32'h12345037, 1'b0);
    in_valid = 1'b0;
    check("pre_rst_vld", {63'd0, out_valid32}, 64'd1);
    #2;
    rst_n = 1'b0;
    q.delete();
    stall_prev = 1'b0;
    #1;
    check("async_rst_vld", {62'd0, out_valid32, out_valid64}, 64'd0);
    check("async_rst_imm", {32'd0, imm32}, 64'd0);
    check("async_rst_rdy", {63'd0, in_ready32}, 64'd1);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_rdy", {62'd0, in_ready32, in_ready64}, 64'd3);
    check("post_rst_vld", {63'd0, out_valid32}, 64'd0);
    out_ready = 1'b1;
    chk_vec("post_rst", 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/riscv_immgen_pipe.md
RISCV_IMMGEN_PIPE -- requirements
Module: riscv_immgen_pipe

Interface
REQ-001 SHALL have parameter: XLEN, default 32, immediate width; legal values 32 or 64.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  ins_code valid this cycle.
REQ-005 SHALL have port: in_ready  output  1  block accepts ins_code this cycle.
REQ-006 SHALL have port: ins_code  input  32  instruction word.
REQ-007 SHALL have port: out_valid  output  1  registered result valid.
REQ-008 SHALL have port: out_ready  input  1  consumer takes result this cycle.
REQ-009 SHALL have port: immediate  output  XLEN  decoded immediate.
REQ-010 SHALL have port: imm_fmt  output  3  format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
REQ-011 SHALL have port: illegal  output  1  unrecognised opcode.

Function
REQ-012 Decode on ins_code[6:0]; every sign extension replicates ins_code[31] up to XLEN.
REQ-013 0000011, 1100111, 0001111, 1110011: I; immediate = sext(ins[31:20]).
REQ-014 0010011: I, except funct3 001/101 -> SHAMT, zero-extended ins[24:20] (XLEN=32) or ins[25:20] (XLEN=64).
REQ-015 0100011: S; sext({ins[31:25],ins[11:7]}).
REQ-016 1100011: B; sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0}).
REQ-017 0110111, 0010111: U; sext({ins[31:12],12'b0}).
REQ-018 1101111: J; sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0}).
REQ-019 0110011: fmt 0, immediate 0, illegal 0.
REQ-020 Any other opcode, including ins[1:0] != 2'b11: fmt 0, immediate 0, illegal 1.
REQ-021 Transfer in on in_valid && in_ready; result appears on outputs exactly one cycle later with out_valid=1.
REQ-022 While out_valid && !out_ready: immediate, imm_fmt, illegal and out_valid SHALL hold stable.
REQ-023 No instruction lost, duplicated or reordered under any in_valid/out_ready pattern.
REQ-024 Simultaneous accept and drain: new result replaces drained one in the same edge; out_valid stays 1.

Reset
REQ-025 rst_n low SHALL immediately clear out_valid, immediate, imm_fmt, illegal and all buffered state, independent of clk.
REQ-026 During and after reset, in_ready = 1; reset mid-stall discards pending results.

Configuration
REQ-027 Macro IMMGEN_SKID_EN selects the buffering scheme.
REQ-028 Without it: in_ready = !out_valid || out_ready (combinational); single output register.
REQ-029 With it: one skid entry added; in_ready is registered and equals "skid empty"; an input accepted while the output is stalled enters the skid; on out_ready the skid moves to the output; sustained 1/cycle throughput; no combinational path out_ready -> in_ready.

Verification
REQ-030 ins_code 0xFFF00093 (addi -1) -> next cycle out_valid=1, immediate 0xFFFFFFFF, imm_fmt 1.
REQ-031 0xFE20AE23 (sw, -4) -> 0xFFFFFFFC, fmt 2; 0xFE000CE3 (beq, -8) -> 0xFFFFFFF8, fmt 3.
REQ-032 0x01F09093 (slli 31) -> 0x0000001F, fmt 6; XLEN=64, 0x800000B7 (lui) -> 0xFFFFFFFF80000000, fmt 4.
REQ-033 0x0000007F -> illegal 1, immediate 0, fmt 0.
REQ-034 in_valid held 1, out_ready 0 for 3 cycles: without skid, 1 accepted; with skid, 2 accepted then in_ready 0; release out_ready -> results drained in order, none dropped or duplicated.
REQ-035 rst_n low while out_valid=1 stalled -> out_valid 0 without a clk edge; after release, in_ready 1 and the next accept completes normally.
